// File: rtl/mdll_pkg.sv
// Shared sizes, FSM state type and SAR bit-mask helper for the MDLL frequency-calibration search.
package mdll_pkg;

  localparam int N_DCO_O    = 6;
  localparam int N_FCAL_CNT = 12;
  localparam int N_DCO_B    = (N_DCO_O > 1) ? $clog2(N_DCO_O) : 1;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SETTLE,
    REQ,
    ACK,
    DECIDE,
    FINAL,
    DONE,
    ERR
  } fcal_search_state_t;

  // One-hot mask for the SAR bit currently under trial.
  function automatic logic [N_DCO_O-1:0] sar_bit(input logic [N_DCO_B-1:0] idx);
    logic [N_DCO_O-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mdll_fcal_search_if.sv
// Control/result bus and MDLL fcal handshake bundle; master is the search engine side.
interface mdll_fcal_search_if import mdll_pkg::*; ();

  logic                  start;
  logic [N_FCAL_CNT-1:0] target_cnt;
  logic                  busy;
  logic                  done;
  logic                  err_tmo;
  logic [N_DCO_O-1:0]    result_code;
  logic [N_FCAL_CNT-1:0] result_cnt;
  logic                  en_fcal;
  logic [N_DCO_O-1:0]    dco_ctl_offset;
  logic                  load_offset;
  logic                  fcal_start;
  logic                  fcal_ready;
  logic [N_FCAL_CNT-1:0] fcal_cnt;

  modport master (
    input  start, target_cnt, fcal_ready, fcal_cnt,
    output busy, done, err_tmo, result_code, result_cnt,
           en_fcal, dco_ctl_offset, load_offset, fcal_start
  );

  modport slave (
    output start, target_cnt, fcal_ready, fcal_cnt,
    input  busy, done, err_tmo, result_code, result_cnt,
           en_fcal, dco_ctl_offset, load_offset, fcal_start
  );

endinterface

// File: rtl/mdll_sync2.sv
// Two-flop synchronizer bringing the asynchronous MDLL acknowledge into the clk domain.
module mdll_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/mdll_fcal_search.sv
// MSB-first SAR search of dco_ctl_offset against a target fcal count, plus a final re-measure pass.
// Define MDLL_FCAL_SEARCH_AVG_EN to average four fcal handshakes per measurement.
module mdll_fcal_search
  import mdll_pkg::*;
#(
  parameter int SETTLE_CYC = 64,
  parameter int TMO_CYC    = 4096,
  parameter bit CNT_DEC    = 1'b1
) (
  input logic              clk,
  input logic              rst,
  mdll_fcal_search_if.master bus
);

  localparam int CW = $clog2((TMO_CYC > SETTLE_CYC) ? TMO_CYC : SETTLE_CYC) + 1;
  localparam logic [CW-1:0]      SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]      TMO_LAST    = CW'(TMO_CYC - 1);
  localparam logic [N_DCO_B-1:0] MSB_IDX     = N_DCO_B'(N_DCO_O - 1);

  fcal_search_state_t    state_q, state_d;
  logic [N_DCO_O-1:0]    code_q, code_d;
  logic [N_DCO_O-1:0]    offset_q, offset_d;
  logic [N_DCO_O-1:0]    res_code_q, res_code_d;
  logic [N_DCO_B-1:0]    bit_q, bit_d;
  logic [N_FCAL_CNT-1:0] target_q, target_d;
  logic [N_FCAL_CNT-1:0] meas_q, meas_d;
  logic [N_FCAL_CNT-1:0] res_cnt_q, res_cnt_d;
  logic [CW-1:0]         tmr_q, tmr_d;
  logic                  final_q, final_d;
  logic                  seen_low_q, seen_low_d;
  logic                  err_q, err_d;
  logic [N_FCAL_CNT-1:0] meas_now;
  logic [N_DCO_O-1:0]    next_code;
  logic                  keep;
  logic                  rdy_s;
`ifdef MDLL_FCAL_SEARCH_AVG_EN
  logic [N_FCAL_CNT+1:0] sum_q, sum_d;
  logic [1:0]            hs_q, hs_d;
`endif

  mdll_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.fcal_ready),
    .q_o (rdy_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= '0;
      offset_q   <= '0;
      res_code_q <= '0;
      bit_q      <= '0;
      target_q   <= '0;
      meas_q     <= '0;
      res_cnt_q  <= '0;
      tmr_q      <= '0;
      final_q    <= 1'b0;
      seen_low_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef MDLL_FCAL_SEARCH_AVG_EN
      sum_q      <= '0;
      hs_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      offset_q   <= offset_d;
      res_code_q <= res_code_d;
      bit_q      <= bit_d;
      target_q   <= target_d;
      meas_q     <= meas_d;
      res_cnt_q  <= res_cnt_d;
      tmr_q      <= tmr_d;
      final_q    <= final_d;
      seen_low_q <= seen_low_d;
      err_q      <= err_d;
`ifdef MDLL_FCAL_SEARCH_AVG_EN
      sum_q      <= sum_d;
      hs_q       <= hs_d;
`endif
    end
  end

  // offset_q is updated on the way into LOAD so the strobe and the code reach the MDLL together.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    offset_d   = offset_q;
    res_code_d = res_code_q;
    bit_d      = bit_q;
    target_d   = target_q;
    meas_d     = meas_q;
    res_cnt_d  = res_cnt_q;
    tmr_d      = tmr_q;
    final_d    = final_q;
    seen_low_d = seen_low_q;
    err_d      = err_q;
`ifdef MDLL_FCAL_SEARCH_AVG_EN
    sum_d      = sum_q;
    hs_d       = hs_q;
    meas_now   = sum_q[N_FCAL_CNT+1:2];
`else
    meas_now   = meas_q;
`endif
    keep      = CNT_DEC ? (meas_q > target_q) : (meas_q < target_q);
    next_code = keep ? offset_q : code_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          target_d = bus.target_cnt;
          code_d   = '0;
          bit_d    = MSB_IDX;
          offset_d = sar_bit(MSB_IDX);
          err_d    = 1'b0;
          final_d  = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        tmr_d   = '0;
`ifdef MDLL_FCAL_SEARCH_AVG_EN
        sum_d   = '0;
        hs_d    = '0;
`endif
        state_d = SETTLE;
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d      = '0;
          seen_low_d = 1'b0;
          state_d    = REQ;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      // A ready that is already high on entry is stale; only a rise after a seen low is accepted.
      REQ: begin
        if (rdy_s && seen_low_q) begin
`ifdef MDLL_FCAL_SEARCH_AVG_EN
          sum_d = sum_q + {2'b00, bus.fcal_cnt};
`else
          meas_d = bus.fcal_cnt;
`endif
          tmr_d   = '0;
          state_d = ACK;
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          tmr_d = tmr_q + 1'b1;
          if (!rdy_s) begin
            seen_low_d = 1'b1;
          end
        end
      end
      ACK: begin
        if (!rdy_s) begin
          tmr_d = '0;
`ifdef MDLL_FCAL_SEARCH_AVG_EN
          if (hs_q != 2'd3) begin
            hs_d       = hs_q + 2'd1;
            seen_low_d = 1'b1;
            state_d    = REQ;
          end else begin
            meas_d  = meas_now;
            state_d = final_q ? DONE : DECIDE;
          end
`else
          state_d = final_q ? DONE : DECIDE;
`endif
          if (final_q && (state_d == DONE)) begin
            res_code_d = code_q;
            res_cnt_d  = meas_now;
          end
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DECIDE: begin
        code_d = next_code;
        if (bit_q == '0) begin
          state_d = FINAL;
        end else begin
          bit_d    = bit_q - 1'b1;
          offset_d = next_code | sar_bit(bit_q - 1'b1);
          state_d  = LOAD;
        end
      end
      FINAL: begin
        final_d  = 1'b1;
        offset_d = code_q;
        state_d  = LOAD;
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy           = (state_q != IDLE) && (state_q != ERR);
  assign bus.en_fcal        = (state_q != IDLE) && (state_q != ERR);
  assign bus.done           = (state_q == DONE);
  assign bus.load_offset    = (state_q == LOAD);
  assign bus.fcal_start     = (state_q == REQ);
  assign bus.err_tmo        = err_q;
  assign bus.result_code    = res_code_q;
  assign bus.result_cnt     = res_cnt_q;
  assign bus.dco_ctl_offset = offset_q;

endmodule
